// File: rtl/spi_slave_bridge_param.sv
// spi_slave_bridge_param: SPI slave (all four modes, WORD_W-bit words) bridged into the clk domain.
module spi_slave_bridge_param #(
  parameter int WORD_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [1:0]        mode,
  input  logic [WORD_W-1:0] tx_data,
  output logic              tx_load,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              abort,
  output logic              busy
);
  localparam int CW = $clog2(WORD_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, mosi_sy;
  logic sclk_d, cs_d;
  logic [1:0] mode_q;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-2:0] rx_shift;
  logic [CW-1:0] cnt, cnt_nx;
  logic reload;
  logic sclk_s, cs_s, mosi_s, rise, fall, lead, trail, sample, shift_e, done, cs_fall, cs_rise;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sy <= '0;
      cs_sy <= '1;
      mosi_sy <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      cs_sy <= {cs_sy[SYNC_STAGES-2:0], cs_n};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_sy[SYNC_STAGES-1];
      cs_d <= cs_sy[SYNC_STAGES-1];
    end
  end
  always_comb begin
    sclk_s = sclk_sy[SYNC_STAGES-1];
    cs_s = cs_sy[SYNC_STAGES-1];
    mosi_s = mosi_sy[SYNC_STAGES-1];
    rise = sclk_s & ~sclk_d;
    fall = ~sclk_s & sclk_d;
    lead = mode_q[1] ? fall : rise;
    trail = mode_q[1] ? rise : fall;
    sample = mode_q[0] ? trail : lead;
    shift_e = mode_q[0] ? lead : trail;
    done = sample && (cnt == CW'(WORD_W-1));
    cnt_nx = done ? '0 : sample ? cnt + CW'(1) : cnt;
    cs_fall = cs_d & ~cs_s;
    cs_rise = ~cs_d & cs_s;
  end
  // CPHA=0 puts the MSB on miso at frame start, so the shifter is preloaded one bit ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= 2'b00;
      tx_shift <= '0;
      rx_shift <= '0;
      cnt <= '0;
      reload <= 1'b0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      tx_load <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      abort <= 1'b0;
      busy <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      rx_valid <= 1'b0;
      abort <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          state <= ACTIVE;
          busy <= 1'b1;
          mode_q <= mode;
          tx_shift <= mode[0] ? tx_data : {tx_data[WORD_W-2:0], 1'b0};
          tx_load <= 1'b1;
          cnt <= '0;
          miso_oe <= 1'b1;
          miso <= mode[0] ? 1'b0 : tx_data[WORD_W-1];
        end
      end else if (cs_rise) begin
        state <= IDLE;
        busy <= 1'b0;
        miso_oe <= 1'b0;
        miso <= 1'b0;
        cnt <= '0;
        rx_shift <= '0;
        reload <= 1'b0;
        abort <= cnt_nx != '0;
        if (done) begin
          rx_data <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
      end else begin
        cnt <= cnt_nx;
        reload <= done;
        if (sample) rx_shift <= {rx_shift[WORD_W-3:0], mosi_s};
        if (done) begin
          rx_data <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
        // Reload lags rx_valid by one cycle so the core can present the next word.
        if (reload) begin
          tx_shift <= tx_data;
          tx_load <= 1'b1;
        end else if (shift_e) begin
          miso <= tx_shift[WORD_W-1];
          tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
        end
      end
    end
  end
endmodule
